// File: rtl/riscv_pkg.sv
// Shared RISC-V constants and the register-file sequencer state encoding.
package riscv_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned REG_COUNT  = 32;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } regfile_state_t;

endpackage

// File: rtl/regfile_clear_seq.sv
// Post-reset clear sequencer: walks every register address once, emitting a
// zero-write strobe, then enters RUN (terminal until reset) and raises ready.
module regfile_clear_seq
    import riscv_pkg::*;
#(
    parameter int unsigned DEPTH  = REG_COUNT,
    parameter int unsigned ADDR_W = REG_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr,
    output logic              ready
);

    regfile_state_t    state_q, state_d;
    logic [ADDR_W-1:0] clr_idx_q, clr_idx_d;
    logic              ready_q, ready_d;

    // Next-state: advance the clear index, leave CLEAR after the last entry.
    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        ready_d   = ready_q;
        case (state_q)
            CLEAR: begin
                clr_idx_d = clr_idx_q + 1'b1;
                if (clr_idx_q == ADDR_W'(DEPTH - 1)) begin
                    state_d = RUN;
                    ready_d = 1'b1;
                end
            end
            RUN: begin
                state_d = RUN;
            end
            default: begin
                state_d = CLEAR;
            end
        endcase
    end

    // Sequencer state with registered ready.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= CLEAR;
            clr_idx_q <= '0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
            ready_q   <= ready_d;
        end
    end

    assign clr_we   = (state_q == CLEAR);
    assign clr_addr = clr_idx_q;
    assign ready    = ready_q;

endmodule

// File: rtl/regfile_2r1w.sv
// RISC-V integer register file, one write port and two registered read ports.
// x0 always reads as zero. The array has no reset (RAM-mappable); a clear
// sequencer zeroes it after reset before ready rises.
// Optional feature macro: REGFILE_BYPASS_EN -- same-cycle write data is
// forwarded to a read of the same (non-zero) address.
module regfile_2r1w
    import riscv_pkg::*;
#(
    parameter int unsigned WIDTH  = XLEN,
    parameter int unsigned DEPTH  = REG_COUNT,
    parameter int unsigned ADDR_W = REG_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rs1_addr,
    input  logic [ADDR_W-1:0] rs2_addr,
    output logic [WIDTH-1:0]  rs1_data,
    output logic [WIDTH-1:0]  rs2_data,
    output logic              rd_valid,
    output logic              ready
);

    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [WIDTH-1:0]  mem_wdata;
    logic [WIDTH-1:0]  mem_q [DEPTH];

    logic [WIDTH-1:0]  rs1_rd, rs2_rd;
    logic [WIDTH-1:0]  rs1_data_q, rs1_data_d;
    logic [WIDTH-1:0]  rs2_data_q, rs2_data_d;
    logic              rd_valid_q, rd_valid_d;

    regfile_clear_seq #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_clear_seq (
        .clk      (clk),
        .rst      (rst),
        .clr_we   (clr_we),
        .clr_addr (clr_addr),
        .ready    (ready)
    );

    // Array write port: clear sequencer owns it until ready, x0 writes dropped.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = wr_addr;
        mem_wdata = wr_data;
        if (clr_we) begin
            mem_we    = 1'b1;
            mem_waddr = clr_addr;
            mem_wdata = '0;
        end else if (ready && wr_en && (wr_addr != '0)) begin
            mem_we = 1'b1;
        end
    end

    // Storage array, intentionally without reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    // Combinational read value with x0 masking and optional write forwarding.
    always_comb begin
`ifdef REGFILE_BYPASS_EN
        rs1_rd = (wr_en && (wr_addr == rs1_addr)) ? wr_data : mem_q[rs1_addr];
        rs2_rd = (wr_en && (wr_addr == rs2_addr)) ? wr_data : mem_q[rs2_addr];
`else
        rs1_rd = mem_q[rs1_addr];
        rs2_rd = mem_q[rs2_addr];
`endif
        if (rs1_addr == '0) begin
            rs1_rd = '0;
        end
        if (rs2_addr == '0) begin
            rs2_rd = '0;
        end
    end

    // Read registers: capture on rd_en in RUN, otherwise hold; valid is a pulse.
    always_comb begin
        rs1_data_d = rs1_data_q;
        rs2_data_d = rs2_data_q;
        rd_valid_d = 1'b0;
        if (ready && rd_en) begin
            rs1_data_d = rs1_rd;
            rs2_data_d = rs2_rd;
            rd_valid_d = 1'b1;
        end
    end

    // Read-port output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rs1_data_q <= rs1_data_d;
            rs2_data_q <= rs2_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign rs1_data = rs1_data_q;
    assign rs2_data = rs2_data_q;
    assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_regfile_2r1w.sv
// Self-checking bench for regfile_2r1w: vector table plus read scoreboard.
module tb_regfile_2r1w;

    logic        clk;
    logic        rst;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        rd_en;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        rd_valid;
    logic        ready;

    regfile_2r1w dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_en    (rd_en),
        .rs1_addr (rs1_addr),
        .rs2_addr (rs2_addr),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .rd_valid (rd_valid),
        .ready    (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef REGFILE_BYPASS_EN
    localparam logic [31:0] BYP7  = 32'hA5A5A5A5;
    localparam logic [31:0] BYP31 = 32'hCAFEF00D;
`else
    localparam logic [31:0] BYP7  = 32'h00000011;
    localparam logic [31:0] BYP31 = 32'h00000000;
`endif

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        re;
        logic [4:0]  a1;
        logic [4:0]  a2;
        logic [31:0] e1;
        logic [31:0] e2;
    } vec_t;

    localparam int NVEC = 16;
    vec_t vecs [NVEC];

    logic [63:0] sb [$];
    int          n_cmp;
    int          n_fail;
    logic        tb_run;
    logic [31:0] last1;
    logic [31:0] last2;

    task automatic check1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock: drive inputs, pass the edge, then check read outputs.
    task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic re, input logic [4:0] a1, input logic [4:0] a2,
                         input logic [31:0] e1, input logic [31:0] e2);
        logic        exp_v;
        logic [63:0] exp;
        wr_en    = we;
        wr_addr  = wa;
        wr_data  = wd;
        rd_en    = re;
        rs1_addr = a1;
        rs2_addr = a2;
        exp_v    = tb_run && re;
        if (exp_v) sb.push_back({e1, e2});
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        check1("rd_valid", rd_valid, exp_v);
        if (exp_v) begin
            exp = sb.pop_front();
            check32("rs1_data", rs1_data, exp[63:32]);
            check32("rs2_data", rs2_data, exp[31:0]);
            last1 = exp[63:32];
            last2 = exp[31:0];
        end else begin
            check32("rs1_hold", rs1_data, last1);
            check32("rs2_hold", rs2_data, last2);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        tb_run = 1'b0;
        last1  = '0;
        last2  = '0;
        sb.delete();
        check32("rst_rs1", rs1_data, 32'h0);
        check32("rst_rs2", rs2_data, 32'h0);
        check1("rst_valid", rd_valid, 1'b0);
        check1("rst_ready", ready, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check1("ready_c0", ready, 1'b0);
    endtask

    // Clear cycles; optional write/read traffic that must be ignored.
    task automatic clear_wait(input int n, input logic active);
        for (int c = 0; c < n; c++) begin
            drive(active, 5'(c + 31), 32'hFFFFFFFF, active, 5'(c), 5'(c + 1), 32'h0, 32'h0);
            check1("ready_clear", ready, c == 31);
        end
    endtask

    task automatic read_all(input logic [31:0] v);
        for (int i = 1; i < 32; i++) begin
            drive(1'b0, 5'd0, 32'h0, 1'b1, 5'(i), 5'(32 - i), v, v);
        end
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 32'h0, 32'h0);
    endtask

    initial begin
        n_cmp    = 0;
        n_fail   = 0;
        rst      = 1'b0;
        wr_en    = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        rd_en    = 1'b0;
        rs1_addr = '0;
        rs2_addr = '0;
        tb_run   = 1'b0;
        last1    = '0;
        last2    = '0;

        vecs[0]  = '{1'b1, 5'd5,  32'h12345678, 1'b0, 5'd0,  5'd0, 32'h0,        32'h0};
        vecs[1]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd5,  5'd0, 32'h12345678, 32'h0};
        vecs[2]  = '{1'b1, 5'd0,  32'hFFFFFFFF, 1'b0, 5'd0,  5'd0, 32'h0,        32'h0};
        vecs[3]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd0,  5'd5, 32'h0,        32'h12345678};
        vecs[4]  = '{1'b1, 5'd7,  32'h00000011, 1'b0, 5'd0,  5'd0, 32'h0,        32'h0};
        vecs[5]  = '{1'b1, 5'd7,  32'hA5A5A5A5, 1'b1, 5'd7,  5'd7, BYP7,         BYP7};
        vecs[6]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd7,  5'd5, 32'hA5A5A5A5, 32'h12345678};
        vecs[7]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd1,  5'd2, 32'h0,        32'h0};
        vecs[8]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd3,  5'd4, 32'h0,        32'h0};
        vecs[9]  = '{1'b1, 5'd31, 32'hCAFEF00D, 1'b1, 5'd31, 5'd0, BYP31,        32'h0};
        vecs[10] = '{1'b1, 5'd0,  32'h00001234, 1'b1, 5'd0,  5'd0, 32'h0,        32'h0};
        vecs[11] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd31, 5'd1, 32'hCAFEF00D, 32'h0};
        vecs[12] = '{1'b1, 5'd1,  32'h00000001, 1'b1, 5'd2,  5'd2, 32'h0,        32'h0};
        vecs[13] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd1,  5'd7, 32'h00000001, 32'hA5A5A5A5};
        vecs[14] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd7,  5'd7, 32'h0,        32'h0};
        vecs[15] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd0, 32'h0,        32'h0};

        // Bring up, pollute the array through the write port.
        #12;
        do_reset();
        clear_wait(32, 1'b0);
        tb_run = 1'b1;
        for (int i = 1; i < 32; i++) begin
            drive(1'b1, 5'(i), 32'hDEADBEEF, 1'b0, 5'd0, 5'd0, 32'h0, 32'h0);
        end
        read_all(32'hDEADBEEF);

        // Reset mid-RUN: clear must zero the stale contents.
        do_reset();
        clear_wait(32, 1'b0);
        tb_run = 1'b1;
        read_all(32'h0);

        // Table-driven functional vectors.
        for (int v = 0; v < NVEC; v++) begin
            drive(vecs[v].we, vecs[v].wa, vecs[v].wd, vecs[v].re,
                  vecs[v].a1, vecs[v].a2, vecs[v].e1, vecs[v].e2);
        end

        // Reset mid-CLEAR with traffic, then full clear with traffic ignored.
        do_reset();
        clear_wait(10, 1'b1);
        do_reset();
        clear_wait(32, 1'b1);
        tb_run = 1'b1;
        read_all(32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
